// File: rtl/rtc_dk8e_if.sv
// Instruction/state bus between the PDP8e core and the rtc_dk8e clock peripheral.
// The core side (master) drives the major state, instruction and user-mode bit.
// The peripheral side (slave) returns the interrupt request and the IOT skip line.
interface rtc_dk8e_if;
  logic [4:0]  state;
  logic [0:11] instruction;
  logic        UF;
  logic        interrupt;
  logic        skip;

  modport master (
    output state,
    output instruction,
    output UF,
    input  interrupt,
    input  skip
  );

  modport slave (
    input  state,
    input  instruction,
    input  UF,
    output interrupt,
    output skip
  );
endinterface

// File: rtl/rtc_dk8e.sv
// rtc_dk8e: line-frequency real-time clock (DK8-EA style) for the PDP8e core.
// A free-running prescaler raises a clock flag once per tick period. Three IOTs
// on device DEV enable or disable the interrupt and skip-and-clear the flag.
// CAF (6007) clears the flag and the enable and restarts the prescaler.
// Optional macro RTC_SIM_EN: when defined, the tick period is forced to 64 clocks
// so simulation reaches ticks quickly. IOT behaviour is identical either way.
module rtc_dk8e #(
  parameter int         CLK_HZ    = 100000000,
  parameter int         TICK_HZ   = 60,
  parameter logic [5:0] DEV       = 6'o13,
  parameter logic [4:0] IOT_STATE = 5'd2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  rtc_dk8e_if.slave bus
);

`ifdef RTC_SIM_EN
  localparam int N = 64;
`else
  localparam int N = CLK_HZ / TICK_HZ;
`endif
  localparam int              CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          int_en_q, int_en_d;
  logic          skip_q, skip_d;
  logic          interrupt_q, interrupt_d;
  logic [4:0]    state_q;

  logic tick;
  logic in_iot;
  logic iot_entry;
  logic dev_hit;
  logic clei, cldi, clsk, caf;

  // Decode the prescaler wrap and the single-cycle IOT entry strobe.
  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    in_iot    = (bus.state == IOT_STATE);
    // An IOT acts only on the first cycle of the IOT state, so a long IOT
    // state cannot execute twice; user mode suppresses it entirely.
    iot_entry = in_iot && (state_q != IOT_STATE) &&
                (bus.instruction[0:2] == 3'o6) && !bus.UF;
    dev_hit   = iot_entry && (bus.instruction[3:8] == DEV);
    clei      = dev_hit && (bus.instruction[9:11] == 3'o1);
    cldi      = dev_hit && (bus.instruction[9:11] == 3'o2);
    clsk      = dev_hit && (bus.instruction[9:11] == 3'o3);
    caf       = iot_entry && (bus.instruction[3:11] == 9'o007);
  end

  // Next-state logic for the prescaler, flag, enable, skip and interrupt.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    flag_d      = flag_q;
    int_en_d    = int_en_q;
    skip_d      = skip_q;
    interrupt_d = flag_q & int_en_q;

    // Skip is sampled at IOT entry and held for the rest of the IOT state.
    if (!in_iot)
      skip_d = 1'b0;
    else if (iot_entry)
      skip_d = clsk & flag_q;

    if (clei) int_en_d = 1'b1;
    if (cldi) int_en_d = 1'b0;
    if (clsk) flag_d   = 1'b0;
    // A tick coinciding with CLSK must not be lost: the set overrides the clear.
    if (tick) flag_d   = 1'b1;

    // CAF restarts the whole peripheral, including a coincident tick.
    if (caf) begin
      cnt_d    = '0;
      flag_d   = 1'b0;
      int_en_d = 1'b0;
    end
  end

  // State registers; reset and front-panel clear take priority over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset || clear) begin
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      int_en_q    <= 1'b0;
      skip_q      <= 1'b0;
      interrupt_q <= 1'b0;
      state_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      int_en_q    <= int_en_d;
      skip_q      <= skip_d;
      interrupt_q <= interrupt_d;
      state_q     <= bus.state;
    end
  end

  assign bus.interrupt = interrupt_q;
  assign bus.skip      = skip_q;

endmodule

// File: tb/tb_rtc_dk8e.sv
// Self-checking bench for rtc_dk8e. The DUT is built with CLK_HZ=64, TICK_HZ=1
// so the tick period is 64 clocks whether or not RTC_SIM_EN is defined.
// Directed scenarios use hand-derived cycle counts; a randomized run is checked
// every cycle against a cycle-count model of the clock's rules.
module tb_rtc_dk8e;
  localparam logic [4:0]  IOT  = 5'd2;
  localparam logic [11:0] CLEI = 12'o6131;
  localparam logic [11:0] CLDI = 12'o6132;
  localparam logic [11:0] CLSK = 12'o6133;
  localparam logic [11:0] CAF  = 12'o6007;
  localparam int          PERIOD = 64;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rtc_dk8e_if bus ();

  rtc_dk8e #(
    .CLK_HZ   (64),
    .TICK_HZ  (1),
    .DEV      (6'o13),
    .IOT_STATE(IOT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .bus  (bus)
  );

  // ---------------------------------------------------------------------------
  // Reference model: elapsed cycles since the last restart decide when a tick
  // happens; flag/enable/skip/interrupt follow the IOT rules directly.
  // ---------------------------------------------------------------------------
  int          m_elapsed;
  bit          m_flag, m_ie, m_skip, m_intr, m_in_iot;
  bit          mt_tick, mt_entry;
  logic [11:0] mt_ins;

  always @(posedge clk) begin
    if (reset || clear) begin
      m_elapsed = 0;
      m_flag    = 0;
      m_ie      = 0;
      m_skip    = 0;
      m_intr    = 0;
      m_in_iot  = 0;
    end else begin
      mt_ins   = bus.instruction;
      mt_tick  = ((m_elapsed % PERIOD) == PERIOD - 1);
      mt_entry = (bus.state == IOT) && !m_in_iot && (mt_ins[11:9] == 3'o6) && !bus.UF;
      m_intr   = m_flag && m_ie;
      if (bus.state != IOT)
        m_skip = 0;
      else if (mt_entry)
        m_skip = (mt_ins == CLSK) ? m_flag : 1'b0;
      if (mt_entry && mt_ins == CAF) begin
        m_flag    = 0;
        m_ie      = 0;
        m_elapsed = 0;
      end else begin
        if (mt_entry && mt_ins == CLEI) m_ie = 1;
        if (mt_entry && mt_ins == CLDI) m_ie = 0;
        if (mt_entry && mt_ins == CLSK) m_flag = 0;
        if (mt_tick) m_flag = 1;
        m_elapsed = m_elapsed + 1;
      end
      m_in_iot = (bus.state == IOT);
    end
  end

  // Hold reset for two edges and release it on a falling edge; the next rising
  // edge is cycle 1 of counting.
  task automatic do_reset();
    reset           = 1'b1;
    clear           = 1'b0;
    bus.state       = 5'd0;
    bus.instruction = 12'o0;
    bus.UF          = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_iot(input logic [11:0] ins);
    bus.state       = IOT;
    bus.instruction = ins;
  endtask

  task automatic drive_idle();
    bus.state       = 5'd0;
    bus.instruction = 12'o0;
    bus.UF          = 1'b0;
  endtask

  // Reset values, no spurious outputs before the first tick, flag set by cycle 65.
  task automatic test_reset();
    reset = 1'b1;
    clear = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.skip !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_skip: got %b expected 0", bus.skip);
    end
    n_checks++;
    if (bus.interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_interrupt: got %b expected 0", bus.interrupt);
    end
    reset = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.interrupt !== 1'b0 || bus.skip !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_outputs: cycle %0d got int=%b skip=%b expected 0/0",
                 k, bus.interrupt, bus.skip);
      end
    end
    drive_iot(CLSK);
    @(negedge clk);
    n_checks++;
    if (bus.skip !== 1'b1) begin
      n_fail++;
      $display("FAIL first_tick_flag: skip got %b expected 1", bus.skip);
    end
    drive_idle();
    @(negedge clk);
  endtask

  // CLEI then first tick: interrupt rises at cycle 65; CLDI drops it two cycles
  // after entry; CLEI with flag already set raises it two cycles after entry.
  task automatic test_interrupt_enable();
    do_reset();
    drive_iot(CLEI);
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      if (k == 1) drive_idle();
      n_checks++;
      if (bus.interrupt !== (k >= 65)) begin
        n_fail++;
        $display("FAIL clei_tick_interrupt: cycle %0d got %b expected %b",
                 k, bus.interrupt, (k >= 65));
      end
    end
    drive_iot(CLDI);
    @(negedge clk);
    drive_idle();
    n_checks++;
    if (bus.interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL cldi_lag: got %b expected 1", bus.interrupt);
    end
    @(negedge clk);
    n_checks++;
    if (bus.interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL cldi_off: got %b expected 0", bus.interrupt);
    end
    drive_iot(CLEI);
    @(negedge clk);
    drive_idle();
    n_checks++;
    if (bus.interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL clei_lag: got %b expected 0", bus.interrupt);
    end
    @(negedge clk);
    n_checks++;
    if (bus.interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL clei_rise: got %b expected 1", bus.interrupt);
    end
  endtask

  // Three-cycle CLSK holds skip, clears it on exit; a repeat CLSK skips no more.
  task automatic test_clsk_hold();
    do_reset();
    repeat (64) @(negedge clk);
    drive_iot(CLSK);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus.skip !== 1'b1) begin
        n_fail++;
        $display("FAIL clsk_hold: IOT cycle %0d got %b expected 1", j + 1, bus.skip);
      end
    end
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (bus.skip !== 1'b0) begin
      n_fail++;
      $display("FAIL clsk_exit: got %b expected 0", bus.skip);
    end
    drive_iot(CLSK);
    @(negedge clk);
    n_checks++;
    if (bus.skip !== 1'b0) begin
      n_fail++;
      $display("FAIL clsk_repeat: got %b expected 0", bus.skip);
    end
    drive_idle();
    @(negedge clk);
  endtask

  // CLSK entry on the tick cycle reports the old flag and keeps the new tick.
  task automatic test_tick_collision();
    do_reset();
    repeat (63) @(negedge clk);
    drive_iot(CLSK);
    @(negedge clk);
    n_checks++;
    if (bus.skip !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_old_flag: got %b expected 0", bus.skip);
    end
    drive_idle();
    @(negedge clk);
    drive_iot(CLSK);
    @(negedge clk);
    n_checks++;
    if (bus.skip !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_flag_kept: got %b expected 1", bus.skip);
    end
    drive_idle();
    @(negedge clk);
  endtask

  // CAF and front-panel clear both drop flag/enable and restart the prescaler.
  task automatic test_caf_and_clear();
    do_reset();
    drive_iot(CLEI);
    @(negedge clk);
    drive_idle();
    repeat (69) @(negedge clk);
    n_checks++;
    if (bus.interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL caf_setup: got %b expected 1", bus.interrupt);
    end
    drive_iot(CAF);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (bus.interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL caf_int_off: got %b expected 0", bus.interrupt);
    end
    drive_iot(CLEI);
    for (int k = 73; k <= 136; k++) begin
      @(negedge clk);
      if (k == 73) drive_idle();
      n_checks++;
      if (bus.interrupt !== (k >= 136)) begin
        n_fail++;
        $display("FAIL caf_restart: cycle %0d got %b expected %b",
                 k, bus.interrupt, (k >= 136));
      end
    end
    repeat (14) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++;
    if (bus.interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_int_off: got %b expected 0", bus.interrupt);
    end
    drive_iot(CLEI);
    for (int k = 152; k <= 216; k++) begin
      @(negedge clk);
      if (k == 152) drive_idle();
      n_checks++;
      if (bus.interrupt !== (k >= 216)) begin
        n_fail++;
        $display("FAIL clear_restart: cycle %0d got %b expected %b",
                 k, bus.interrupt, (k >= 216));
      end
    end
  endtask

  // User mode suppresses CLSK; back-to-back IOTs with one idle cycle both run.
  task automatic test_user_mode_back_to_back();
    do_reset();
    repeat (64) @(negedge clk);
    bus.UF = 1'b1;
    drive_iot(CLSK);
    @(negedge clk);
    n_checks++;
    if (bus.skip !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_skip: got %b expected 0", bus.skip);
    end
    drive_idle();
    @(negedge clk);
    drive_iot(CLSK);
    @(negedge clk);
    n_checks++;
    if (bus.skip !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_flag_kept: got %b expected 1", bus.skip);
    end
    drive_idle();
    @(negedge clk);
    drive_iot(CLSK);
    @(negedge clk);
    n_checks++;
    if (bus.skip !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_exec: got %b expected 0", bus.skip);
    end
    drive_idle();
    @(negedge clk);
  endtask

  // Random instruction/state/UF/clear traffic compared every cycle to the model.
  task automatic test_random();
    logic [11:0] pool [9] = '{CLEI, CLDI, CLSK, CAF, 12'o6130, 12'o6137,
                              12'o6001, CLSK, CLEI};
    logic [31:0] r;
    int          iot_left;
    do_reset();
    iot_left = 0;
    for (int c = 0; c < 4000; c++) begin
      clear = ($urandom_range(0, 199) == 0);
      if (iot_left > 0) begin
        bus.state = IOT;
        iot_left--;
      end else if ($urandom_range(0, 3) == 0) begin
        r = $urandom;
        bus.instruction = ($urandom_range(0, 7) == 0) ? r[11:0] : pool[$urandom_range(0, 8)];
        bus.UF          = ($urandom_range(0, 7) == 0);
        bus.state       = IOT;
        iot_left        = $urandom_range(0, 2);
      end else begin
        r = $urandom;
        bus.state = (r[4:0] == IOT) ? 5'd0 : r[4:0];
      end
      @(negedge clk);
      n_checks++;
      if (bus.skip !== m_skip || bus.interrupt !== m_intr) begin
        n_fail++;
        $display("FAIL random_outputs: cycle %0d got skip=%b int=%b expected skip=%b int=%b",
                 c, bus.skip, bus.interrupt, m_skip, m_intr);
      end
    end
    clear = 1'b0;
    drive_idle();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_interrupt_enable();
    test_clsk_hold();
    test_tick_collision();
    test_caf_and_clear();
    test_user_mode_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
